// File: rtl/mult_wb_buffer.sv
// mult_wb_buffer: write-back buffer behind the pipelined multiplier chain.
// Tracks the tag and func of each issued op in a delay line that matches the
// chain latency, pairs each product with its tag on mult_done, selects the
// 32-bit result word, queues it in a small FIFO, and presents it on the CDB.
// Credits on issue_ready keep the non-stallable chain from overflowing the FIFO.
//
// Parameters: STAGES (chain latency), DEPTH (FIFO entries), TAG_W (tag width)
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   issue_valid/tag/func: op entering the chain this cycle
//   issue_ready         : a credit is available
//   mult_done/product   : chain last-stage outputs
//   cdb_valid/tag/value : result handshake, cdb_ready is the grant
//   err_sticky          : protocol violation seen, cleared only by reset
// Optional feature: define MULT_WB_BYPASS_EN to forward a capture straight to
// the CDB in the done cycle when the FIFO is empty.

`ifndef MULT_STAGES
`define MULT_STAGES 8
`endif

module mult_wb_buffer #(
    parameter int STAGES = `MULT_STAGES,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [1:0]       issue_func,
    output logic             issue_ready,
    input  logic             mult_done,
    input  logic [63:0]      mult_product,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_value,
    input  logic             cdb_ready,
    output logic             err_sticky
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(STAGES + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    // Delay line, aligned so that entry STAGES-1 lines up with mult_done.
    logic [STAGES-1:0] r_dl_valid;
    logic [TAG_W-1:0]  r_dl_tag  [STAGES];
    logic [1:0]        r_dl_func [STAGES];

    // Result FIFO storage and state.
    logic [TAG_W-1:0]  r_fifo_tag [DEPTH];
    logic [31:0]       r_fifo_val [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_err;

    logic [IW-1:0]     w_inflight;
    logic              w_tail_valid;
    logic [TAG_W-1:0]  w_tail_tag;
    logic [1:0]        w_tail_func;
    logic              w_capture;
    logic [31:0]       w_word;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_wr_en;
    logic              w_err_set;

    assign w_tail_valid = r_dl_valid[STAGES-1];
    assign w_tail_tag   = r_dl_tag[STAGES-1];
    assign w_tail_func  = r_dl_func[STAGES-1];
    assign w_capture    = mult_done && w_tail_valid;

    // MUL keeps the low word; the high-word variants all take product[63:32]
    // because the chain receives operands already extended to 64 bits.
    assign w_word = (w_tail_func == 2'b00) ? mult_product[31:0]
                                           : mult_product[63:32];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_inflight = w_inflight + IW'(r_dl_valid[i]);
        end
    end

    // Everything issued and not yet retired counts against the FIFO.
    assign issue_ready = (SW'(r_count) + SW'(w_inflight)) < SW'(DEPTH);

`ifdef MULT_WB_BYPASS_EN
    logic w_bypass;

    assign w_bypass  = w_capture && w_empty;
    assign cdb_valid = !w_empty || w_capture;
    assign cdb_tag   = !w_empty ? r_fifo_tag[r_rd_ptr] :
                       (w_capture ? w_tail_tag : '0);
    assign cdb_value = !w_empty ? r_fifo_val[r_rd_ptr] :
                       (w_capture ? w_word : '0);
    assign w_pop     = !w_empty && cdb_ready;
    // A bypassed result taken in the same cycle never touches the FIFO.
    assign w_push    = w_capture && !(w_bypass && cdb_ready);
`else
    assign cdb_valid = !w_empty;
    assign cdb_tag   = !w_empty ? r_fifo_tag[r_rd_ptr] : '0;
    assign cdb_value = !w_empty ? r_fifo_val[r_rd_ptr] : '0;
    assign w_pop     = !w_empty && cdb_ready;
    assign w_push    = w_capture;
`endif

    // Push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_wr_en = w_push && !w_drop;

    assign w_err_set = (issue_valid && !issue_ready)
                     || (mult_done && !w_tail_valid)
                     || (w_tail_valid && !mult_done)
                     || w_drop;

    assign err_sticky = r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dl_valid <= '0;
        end else begin
            r_dl_valid <= {r_dl_valid[STAGES-2:0], issue_valid};
        end
    end

    always_ff @(posedge clock) begin
        r_dl_tag[0]  <= issue_tag;
        r_dl_func[0] <= issue_func;
        for (int i = 1; i < STAGES; i++) begin
            r_dl_tag[i]  <= r_dl_tag[i-1];
            r_dl_func[i] <= r_dl_func[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_fifo_tag[r_wr_ptr] <= w_tail_tag;
            r_fifo_val[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_wr_en) - CW'(w_pop);
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_wb_buffer.sv
// tb_mult_wb_buffer: self-checking bench for mult_wb_buffer.
// Models the multiplier chain as a fixed-latency pipe and keeps a result queue.

module tb_mult_wb_buffer;

    localparam int STAGES = 8;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
`ifdef MULT_WB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic             clock;
    logic             reset;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic [1:0]       issue_func;
    logic             issue_ready;
    logic             mult_done;
    logic [63:0]      mult_product;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             cdb_ready;
    logic             err_sticky;

    logic [63:0]       issue_prod;
    logic              inj_done;
    logic [63:0]       inj_prod;
    logic [STAGES-1:0] ch_v;
    logic [63:0]       ch_p [STAGES];

    int cyc;
    int total;
    int bad;

    typedef struct {
        int               t;
        logic [TAG_W-1:0] tag;
        logic [31:0]      val;
    } exp_t;

    exp_t exp_q[$];

    mult_wb_buffer #(
        .STAGES(STAGES),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_func  (issue_func),
        .issue_ready (issue_ready),
        .mult_done   (mult_done),
        .mult_product(mult_product),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .cdb_ready   (cdb_ready),
        .err_sticky  (err_sticky)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Multiplier chain stand-in: fixed latency, cleared by the same reset.
    always @(posedge clock) begin
        if (reset) ch_v <= '0;
        else ch_v <= {ch_v[STAGES-2:0], issue_valid};
        ch_p[0] <= issue_prod;
        for (int i = 1; i < STAGES; i++) ch_p[i] <= ch_p[i-1];
    end

    assign mult_done    = ch_v[STAGES-1] | inj_done;
    assign mult_product = inj_done ? inj_prod : ch_p[STAGES-1];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_tag   = '0;
        issue_func  = 2'b00;
        issue_prod  = '0;
    endtask

    task automatic issue(input logic [TAG_W-1:0] tag, input logic [1:0] func,
                         input logic [63:0] prod);
        exp_t e;
        issue_valid = 1'b1;
        issue_tag   = tag;
        issue_func  = func;
        issue_prod  = prod;
        e.t   = cyc;
        e.tag = tag;
        e.val = (func == 2'b00) ? prod[31:0] : prod[63:32];
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        inj_done  = 1'b0;
        cdb_ready = 1'b0;
        idle();
        repeat (3) tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        total += 5;
        if (cdb_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0", cdb_valid);
        end
        if (cdb_tag !== '0) begin
            bad++; $display("FAIL reset_tag got=%0h want=0", cdb_tag);
        end
        if (cdb_value !== '0) begin
            bad++; $display("FAIL reset_value got=%0h want=0", cdb_value);
        end
        if (issue_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", issue_ready);
        end
        if (err_sticky !== 1'b0) begin
            bad++; $display("FAIL reset_err got=%b want=0", err_sticky);
        end
        tick();
    endtask

    task automatic test_single(input logic [TAG_W-1:0] tag,
                               input logic [1:0] func,
                               input logic [31:0] want);
        int n;
        int nv;
        int vc;
        do_reset();
        cdb_ready = 1'b1;
        n = cyc;
        issue(tag, func, 64'h0000_0003_FFFF_FFFE);
        tick();
        idle();
        nv = 0;
        vc = -1;
        for (int k = 1; k < 14; k++) begin
            @(negedge clock);
            if (cdb_valid === 1'b1) begin
                nv++;
                vc = cyc;
                total += 2;
                if (cdb_tag !== tag) begin
                    bad++; $display("FAIL single_tag got=%0d want=%0d", cdb_tag, tag);
                end
                if (cdb_value !== want) begin
                    bad++; $display("FAIL single_value got=%0h want=%0h", cdb_value, want);
                end
            end
            tick();
        end
        total += 3;
        if (nv != 1) begin
            bad++; $display("FAIL single_count got=%0d want=1", nv);
        end
        if (vc - n != STAGES + LAT) begin
            bad++; $display("FAIL single_latency got=%0d want=%0d", vc - n, STAGES + LAT);
        end
        if (err_sticky !== 1'b0) begin
            bad++; $display("FAIL single_err got=%b want=0", err_sticky);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        logic want_rdy;
        do_reset();
        cdb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            want_rdy = (exp_q.size() < DEPTH);
            total++;
            if (issue_ready !== want_rdy) begin
                bad++; $display("FAIL b2b_ready%0d got=%b want=%b", i, issue_ready, want_rdy);
            end
            if (want_rdy) issue(TAG_W'(10 + i), 2'($urandom), {$urandom, $urandom});
            else idle();
            tick();
        end
        idle();
        repeat (12) tick();
        @(negedge clock);
        total += 3;
        if (cdb_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_full_valid got=%b want=1", cdb_valid);
        end
        if (issue_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_full_ready got=%b want=0", issue_ready);
        end
        if (cdb_tag !== TAG_W'(10)) begin
            bad++; $display("FAIL b2b_head_tag got=%0d want=10", cdb_tag);
        end
        tick();
        cdb_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (cdb_valid === 1'b1 && exp_q.size() > 0) begin
                total += 2;
                if (cdb_tag !== exp_q[0].tag) begin
                    bad++; $display("FAIL b2b_order_tag got=%0d want=%0d", cdb_tag, exp_q[0].tag);
                end
                if (cdb_value !== exp_q[0].val) begin
                    bad++; $display("FAIL b2b_order_val got=%0h want=%0h", cdb_value, exp_q[0].val);
                end
                void'(exp_q.pop_front());
                got++;
            end
            tick();
        end
        total += 3;
        if (got != DEPTH) begin
            bad++; $display("FAIL b2b_retired got=%0d want=%0d", got, DEPTH);
        end
        if (issue_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_ready_back got=%b want=1", issue_ready);
        end
        if (err_sticky !== 1'b0) begin
            bad++; $display("FAIL b2b_err got=%b want=0", err_sticky);
        end
    endtask

    // Twelve consecutive issues: the last eight ignore the credit, so their
    // dones land on a full FIFO while the CDB drains one per cycle.
    task automatic test_full_stream();
        int got;
        do_reset();
        got = 0;
        for (int r = 0; r < 32; r++) begin
            if (r < 12) issue(TAG_W'(20 + r), 2'($urandom), {$urandom, $urandom});
            else idle();
            cdb_ready = (r >= 12);
            @(negedge clock);
            if (r >= 12 && r < 20) begin
                total += 2;
                if (cdb_valid !== 1'b1) begin
                    bad++; $display("FAIL full_valid r=%0d got=%b want=1", r, cdb_valid);
                end
                if (issue_ready !== 1'b0) begin
                    bad++; $display("FAIL full_ready r=%0d got=%b want=0", r, issue_ready);
                end
            end
            if (cdb_valid === 1'b1 && cdb_ready && exp_q.size() > 0) begin
                total += 2;
                if (cdb_tag !== exp_q[0].tag) begin
                    bad++; $display("FAIL full_tag got=%0d want=%0d", cdb_tag, exp_q[0].tag);
                end
                if (cdb_value !== exp_q[0].val) begin
                    bad++; $display("FAIL full_val got=%0h want=%0h", cdb_value, exp_q[0].val);
                end
                void'(exp_q.pop_front());
                got++;
            end
            tick();
        end
        total += 2;
        if (got != 12) begin
            bad++; $display("FAIL full_retired got=%0d want=12", got);
        end
        if (err_sticky !== 1'b1) begin
            bad++; $display("FAIL full_err_overissue got=%b want=1", err_sticky);
        end
    endtask

    task automatic test_spurious_done();
        do_reset();
        cdb_ready = 1'b1;
        inj_done  = 1'b1;
        inj_prod  = {$urandom, $urandom};
        @(negedge clock);
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++; $display("FAIL spur_valid0 got=%b want=0", cdb_valid);
        end
        tick();
        inj_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            total += 2;
            if (cdb_valid !== 1'b0) begin
                bad++; $display("FAIL spur_valid got=%b want=0", cdb_valid);
            end
            if (err_sticky !== 1'b1) begin
                bad++; $display("FAIL spur_err got=%b want=1", err_sticky);
            end
            tick();
        end
        do_reset();
        @(negedge clock);
        total++;
        if (err_sticky !== 1'b0) begin
            bad++; $display("FAIL spur_err_clear got=%b want=0", err_sticky);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        cdb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(TAG_W'(40 + i), 2'b00, {$urandom, $urandom});
            tick();
        end
        idle();
        tick();
        do_reset();
        cdb_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            total += 2;
            if (cdb_valid !== 1'b0) begin
                bad++; $display("FAIL rstfl_valid got=%b want=0", cdb_valid);
            end
            if (issue_ready !== 1'b1) begin
                bad++; $display("FAIL rstfl_ready got=%b want=1", issue_ready);
            end
            tick();
        end
        total++;
        if (err_sticky !== 1'b0) begin
            bad++; $display("FAIL rstfl_err got=%b want=0", err_sticky);
        end
    endtask

    // Results become visible STAGES+LAT cycles after issue, strictly in order,
    // and the credit is free whenever fewer than DEPTH ops are unretired.
    task automatic test_random();
        logic want_rdy;
        logic want_v;
        int nbad;
        do_reset();
        nbad = 0;
        for (int k = 0; k < 400; k++) begin
            want_rdy = (exp_q.size() < DEPTH);
            total++;
            if (issue_ready !== want_rdy) begin
                bad++; nbad++;
                if (nbad < 10) $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, issue_ready, want_rdy);
            end
            if (want_rdy && ($urandom % 3 != 0) && k < 380)
                issue(TAG_W'($urandom), 2'($urandom), {$urandom, $urandom});
            else idle();
            cdb_ready = ($urandom % 4 != 0);
            @(negedge clock);
            want_v = (exp_q.size() > 0) && (cyc >= exp_q[0].t + STAGES + LAT);
            total++;
            if (cdb_valid !== want_v) begin
                bad++; nbad++;
                if (nbad < 10) $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, cdb_valid, want_v);
            end
            if (want_v) begin
                total += 2;
                if (cdb_tag !== exp_q[0].tag) begin
                    bad++; nbad++;
                    if (nbad < 10) $display("FAIL rnd_tag got=%0d want=%0d", cdb_tag, exp_q[0].tag);
                end
                if (cdb_value !== exp_q[0].val) begin
                    bad++; nbad++;
                    if (nbad < 10) $display("FAIL rnd_val got=%0h want=%0h", cdb_value, exp_q[0].val);
                end
                if (cdb_ready) void'(exp_q.pop_front());
            end
            tick();
        end
        total += 2;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL rnd_drain got=%0d want=0", exp_q.size());
        end
        if (err_sticky !== 1'b0) begin
            bad++; $display("FAIL rnd_err got=%b want=0", err_sticky);
        end
    endtask

    initial begin
        clock     = 1'b0;
        cyc       = 0;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        inj_done  = 1'b0;
        inj_prod  = '0;
        cdb_ready = 1'b0;
        idle();
        test_reset();
        test_single(TAG_W'(5), 2'b00, 32'hFFFF_FFFE);
        test_single(TAG_W'(9), 2'b11, 32'h0000_0003);
        test_back_to_back();
        test_full_stream();
        test_spurious_done();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
